// File: rtl/audio_mixer.sv
// Sequential volume-weighted mixer: one channel per clock into a signed accumulator, then shift and saturate.
// Latency NUM_CH+1 edges from accepting sample_req to out_valid; requests while busy are dropped and flagged in overrun.
module audio_mixer #(
  parameter int NUM_CH = 4,
  parameter int IN_W   = 8,
  parameter int VOL_W  = 4,
  parameter int OUT_W  = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    sample_req,
  input  logic [NUM_CH*IN_W-1:0]  ch_samples,
  input  logic [NUM_CH*VOL_W-1:0] ch_vol,
  input  logic [NUM_CH-1:0]       ch_enable,
  input  logic                    master_mute,
  output logic [OUT_W-1:0]        audio_output,
  output logic                    out_valid,
  output logic                    busy,
  output logic                    overrun
);

  localparam int ACC_W = IN_W + VOL_W + $clog2(NUM_CH) + 1;
  localparam int SH    = OUT_W - IN_W - VOL_W;
  localparam int SW    = ACC_W + SH;
  localparam int XW    = ((SW > OUT_W) ? SW : OUT_W) + 1;
  localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [IDX_W-1:0]     LAST = IDX_W'(NUM_CH - 1);
  localparam logic signed [XW-1:0] MAXV = {{(XW-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [XW-1:0] MINV = {{(XW-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, ACCUM, SCALE} state_t;
  state_t state, state_nxt;

  logic [NUM_CH*IN_W-1:0]  snap_samples;
  logic [NUM_CH*VOL_W-1:0] snap_vol;
  logic [NUM_CH-1:0]       snap_en;
  logic                    snap_mute;
  logic signed [ACC_W-1:0] acc;
  logic [IDX_W-1:0]        idx;

  logic [IN_W-1:0]         sel_sample;
  logic [VOL_W-1:0]        sel_vol;
  logic                    sel_en;
  logic signed [IN_W-1:0]  centered;
  logic signed [ACC_W-1:0] cen_x, vol_x, term;
  logic signed [XW-1:0]    ext, shifted;
  logic [OUT_W-1:0]        scaled;

  always_comb begin
    sel_sample = '0;
    sel_vol    = '0;
    sel_en     = 1'b0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (idx == IDX_W'(k)) begin
        sel_sample = snap_samples[k*IN_W +: IN_W];
        sel_vol    = snap_vol[k*VOL_W +: VOL_W];
        sel_en     = snap_en[k];
      end
    end
  end

  // Offset-binary to two's complement is just an MSB flip.
  always_comb begin
    centered = {~sel_sample[IN_W-1], sel_sample[IN_W-2:0]};
    cen_x    = {{(ACC_W-IN_W){centered[IN_W-1]}}, centered};
    vol_x    = {{(ACC_W-VOL_W){1'b0}}, sel_vol};
    term     = cen_x * vol_x;
  end

  always_comb begin
    ext     = {{(XW-ACC_W){acc[ACC_W-1]}}, acc};
    shifted = ext <<< SH;
    if (shifted > MAXV)
      scaled = MAXV[OUT_W-1:0];
    else if (shifted < MINV)
      scaled = MINV[OUT_W-1:0];
    else
      scaled = shifted[OUT_W-1:0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (sample_req) state_nxt = ACCUM;
      ACCUM:   if (idx == LAST) state_nxt = SCALE;
      SCALE:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      snap_samples <= '0;
      snap_vol     <= '0;
      snap_en      <= '0;
      snap_mute    <= 1'b0;
      acc          <= '0;
      idx          <= '0;
      audio_output <= '0;
      out_valid    <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      if (sample_req && state != IDLE)
        overrun <= 1'b1;
      case (state)
        IDLE: begin
          if (sample_req) begin
            snap_samples <= ch_samples;
            snap_vol     <= ch_vol;
            snap_en      <= ch_enable;
            snap_mute    <= master_mute;
            acc          <= '0;
            idx          <= '0;
          end
        end
        ACCUM: begin
          if (sel_en)
            acc <= acc + term;
          idx <= idx + IDX_W'(1);
        end
        SCALE: begin
          audio_output <= snap_mute ? '0 : scaled;
          out_valid    <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_audio_mixer.sv
// Bench for audio_mixer at default parameters: fixed vector table, randomized mixes
// against an integer reference model, plus overrun, back-to-back and reset-abort sequences.
module tb_audio_mixer;
  localparam int NUM_CH = 4, IN_W = 8, VOL_W = 4, OUT_W = 16;

  logic                    clk = 1'b0;
  logic                    reset;
  logic                    sample_req;
  logic [NUM_CH*IN_W-1:0]  ch_samples;
  logic [NUM_CH*VOL_W-1:0] ch_vol;
  logic [NUM_CH-1:0]       ch_enable;
  logic                    master_mute;
  logic [OUT_W-1:0]        audio_output;
  logic                    out_valid, busy, overrun;

  int n_checks = 0;
  int n_fail   = 0;

  audio_mixer #(.NUM_CH(NUM_CH), .IN_W(IN_W), .VOL_W(VOL_W), .OUT_W(OUT_W)) dut (
    .clk(clk), .reset(reset), .sample_req(sample_req), .ch_samples(ch_samples),
    .ch_vol(ch_vol), .ch_enable(ch_enable), .master_mute(master_mute),
    .audio_output(audio_output), .out_valid(out_valid), .busy(busy), .overrun(overrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [NUM_CH*IN_W-1:0]  s;
    logic [NUM_CH*VOL_W-1:0] v;
    logic [NUM_CH-1:0]       e;
    logic                    m;
    logic [OUT_W-1:0]        exp_out;
  } vec_t;
  vec_t tbl[10];

  function automatic logic [OUT_W-1:0] model(input logic [NUM_CH*IN_W-1:0] s,
      input logic [NUM_CH*VOL_W-1:0] v, input logic [NUM_CH-1:0] e, input logic m);
    longint sum = 0;
    longint hi  = (longint'(1) <<< (OUT_W-1)) - 1;
    longint lo  = -(longint'(1) <<< (OUT_W-1));
    for (int k = 0; k < NUM_CH; k++)
      if (e[k])
        sum += (longint'(s[k*IN_W +: IN_W]) - (longint'(1) <<< (IN_W-1))) * longint'(v[k*VOL_W +: VOL_W]);
    sum = sum * (longint'(1) <<< (OUT_W-IN_W-VOL_W));
    if (sum > hi) sum = hi;
    if (sum < lo) sum = lo;
    if (m) sum = 0;
    return sum[OUT_W-1:0];
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic scramble();
    ch_samples  = $urandom;
    ch_vol      = 16'($urandom);
    ch_enable   = 4'($urandom);
    master_mute = 1'($urandom);
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    for (int i = 1; i <= 20 && n == 0; i++) begin
      tick();
      if (out_valid) n = i;
    end
  endtask

  task automatic run_mix(input vec_t t, input string nm);
    int n;
    ch_samples = t.s; ch_vol = t.v; ch_enable = t.e; master_mute = t.m;
    sample_req = 1'b1;
    tick();
    sample_req = 1'b0;
    check({nm, " busy"}, 32'(busy), 32'd1);
    scramble();
    wait_valid(n);
    check({nm, " latency"}, 32'(n), 32'd5);
    check({nm, " output"}, 32'(audio_output), 32'(t.exp_out));
    tick();
    check({nm, " valid_one_cycle"}, 32'(out_valid), 32'd0);
    check({nm, " output_hold"}, 32'(audio_output), 32'(t.exp_out));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    vec_t r, a, b;
    int n, cnt;
    tbl[0] = '{32'h0000_00C0, 16'h000F, 4'b0001, 1'b0, 16'h3C00};
    tbl[1] = '{32'hFFFF_FFFF, 16'hFFFF, 4'b1111, 1'b0, 16'h7FFF};
    tbl[2] = '{32'h0000_0000, 16'hFFFF, 4'b1111, 1'b0, 16'h8000};
    tbl[3] = '{32'h0000_00C0, 16'h000F, 4'b0001, 1'b1, 16'h0000};
    tbl[4] = '{32'h8080_8080, 16'hFFFF, 4'b1111, 1'b0, 16'h0000};
    tbl[5] = '{32'h0000_0000, 16'h0001, 4'b0001, 1'b0, 16'hF800};
    tbl[6] = '{32'hFF00_0000, 16'hF000, 4'b1000, 1'b0, 16'h7710};
    tbl[7] = '{32'hFFFF_FFFF, 16'hFFFF, 4'b0000, 1'b0, 16'h0000};
    tbl[8] = '{32'h0000_40C0, 16'h00FF, 4'b0011, 1'b0, 16'h0000};
    tbl[9] = '{32'h0000_FFFF, 16'h002F, 4'b0011, 1'b0, 16'h7FFF};

    reset = 1'b1; sample_req = 1'b0;
    ch_samples = '0; ch_vol = '0; ch_enable = '0; master_mute = 1'b0;
    #12;
    check("reset audio_output", 32'(audio_output), 32'd0);
    check("reset out_valid", 32'(out_valid), 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    check("reset overrun", 32'(overrun), 32'd0);
    tick();
    reset = 1'b0;

    for (int i = 0; i < 10; i++) run_mix(tbl[i], $sformatf("vec%0d", i));

    for (int i = 0; i < 25; i++) begin
      r.s = $urandom; r.v = 16'($urandom); r.e = 4'($urandom);
      r.m = ($urandom_range(0, 3) == 0);
      r.exp_out = model(r.s, r.v, r.e, r.m);
      run_mix(r, $sformatf("rand%0d", i));
    end

    // Request accepted in the same cycle out_valid is high.
    a = tbl[9]; b = tbl[5];
    ch_samples = a.s; ch_vol = a.v; ch_enable = a.e; master_mute = a.m;
    sample_req = 1'b1; tick(); sample_req = 1'b0;
    wait_valid(n);
    check("b2b first latency", 32'(n), 32'd5);
    check("b2b first output", 32'(audio_output), 32'(model(a.s, a.v, a.e, a.m)));
    ch_samples = b.s; ch_vol = b.v; ch_enable = b.e; master_mute = b.m;
    sample_req = 1'b1; tick(); sample_req = 1'b0;
    check("b2b second busy", 32'(busy), 32'd1);
    wait_valid(n);
    check("b2b second latency", 32'(n), 32'd5);
    check("b2b second output", 32'(audio_output), 32'(model(b.s, b.v, b.e, b.m)));
    check("b2b no overrun", 32'(overrun), 32'd0);
    tick();

    // Overrun: second request two cycles after the first.
    a = tbl[0]; b = tbl[1];
    ch_samples = a.s; ch_vol = a.v; ch_enable = a.e; master_mute = a.m;
    sample_req = 1'b1; tick(); sample_req = 1'b0;
    tick();
    ch_samples = b.s; ch_vol = b.v; ch_enable = b.e; master_mute = b.m;
    sample_req = 1'b1; tick(); sample_req = 1'b0;
    check("ovr flag set", 32'(overrun), 32'd1);
    wait_valid(n);
    check("ovr latency", 32'(n), 32'd3);
    check("ovr output first snapshot", 32'(audio_output), 32'h3C00);
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (out_valid) cnt++;
    end
    check("ovr extra valids", 32'(cnt), 32'd0);
    check("ovr sticky", 32'(overrun), 32'd1);

    // Abort: reset pulsed three cycles after the request, checked before any edge.
    ch_samples = a.s; ch_vol = a.v; ch_enable = a.e; master_mute = a.m;
    sample_req = 1'b1; tick(); sample_req = 1'b0;
    tick(); tick(); tick();
    #2 reset = 1'b1;
    #1;
    check("abort audio_output", 32'(audio_output), 32'd0);
    check("abort out_valid", 32'(out_valid), 32'd0);
    check("abort busy", 32'(busy), 32'd0);
    check("abort overrun", 32'(overrun), 32'd0);
    tick();
    reset = 1'b0;
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (out_valid) cnt++;
    end
    check("abort no valid", 32'(cnt), 32'd0);
    check("abort output stays 0", 32'(audio_output), 32'd0);
    run_mix(tbl[0], "post_abort");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/audio_mixer.md
AUDIO_MIXER -- requirements
Module: audio_mixer

Interface
REQ-001 Parameter NUM_CH, default 4: number of mixed channels, range 1..16.
REQ-002 Parameter IN_W, default 8: per-channel sample width, unsigned offset-binary.
REQ-003 Parameter VOL_W, default 4: per-channel volume width, unsigned.
REQ-004 Parameter OUT_W, default 16: mixed output width, two's complement; SHALL satisfy OUT_W >= IN_W+VOL_W.
REQ-005 clk  input  1  single clock; all state changes on its rising edge.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 sample_req  input  1  one-cycle pulse requesting the next mixed sample.
REQ-008 ch_samples  input  NUM_CH*IN_W  channel k occupies bits [k*IN_W +: IN_W].
REQ-009 ch_vol  input  NUM_CH*VOL_W  channel k volume occupies bits [k*VOL_W +: VOL_W].
REQ-010 ch_enable  input  NUM_CH  per-channel enable; 0 contributes zero.
REQ-011 master_mute  input  1  forces the mixed result to zero.
REQ-012 audio_output  output  OUT_W  registered signed mixed sample.
REQ-013 out_valid  output  1  one-cycle pulse when audio_output updates.
REQ-014 busy  output  1  high while a mix is in progress.
REQ-015 overrun  output  1  sticky flag: a sample_req arrived while busy.

Function
REQ-016 FSM states: IDLE, ACCUM, SCALE; busy SHALL equal (state != IDLE).
REQ-017 IDLE with sample_req=1 at edge E0: snapshot ch_samples, ch_vol, ch_enable and master_mute into internal registers; clear accumulator and channel index to 0; go to ACCUM.
REQ-018 ACCUM, edges E1..E(NUM_CH): one channel per edge, index 0 upward; acc += (sample - 2^(IN_W-1)) * vol when enabled, else acc unchanged.
REQ-019 Accumulator SHALL be signed, width IN_W+VOL_W+clog2(NUM_CH)+1; no intermediate overflow is permitted.
REQ-020 After the edge that processes index NUM_CH-1, the FSM SHALL go to SCALE.
REQ-021 SCALE, edge E(NUM_CH+1): compute acc <<< (OUT_W-IN_W-VOL_W) and saturate to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
REQ-022 At that same edge, the FSM SHALL write the result to audio_output, or 0 if the snapshotted mute is set, assert out_valid and return to IDLE.
REQ-023 out_valid SHALL be high for exactly one cycle, NUM_CH+1 edges after the accepting edge (5 at defaults).
REQ-024 audio_output SHALL hold its value between updates.
REQ-025 Input changes after E0 SHALL NOT affect the mix in progress.
REQ-026 sample_req while in ACCUM or SCALE SHALL be ignored and SHALL set overrun to 1; the mix in progress SHALL complete unchanged.
REQ-027 sample_req in the cycle out_valid is high (state IDLE) SHALL be accepted normally.
REQ-028 overrun SHALL clear only on reset.

Reset
REQ-029 While reset=1, asynchronously: state=IDLE, audio_output=0, out_valid=0, busy=0, overrun=0, accumulator=0, index=0.
REQ-030 Reset during ACCUM or SCALE SHALL abort the mix; no out_valid SHALL follow.
REQ-031 After reset deasserts, the first sample_req SHALL be accepted at the next edge.

Verification (defaults NUM_CH=4, IN_W=8, VOL_W=4, OUT_W=16)
REQ-032 Reset: assert reset mid-operation -> audio_output=0x0000, out_valid=0, busy=0, overrun=0 immediately, without waiting for a clock edge.
REQ-033 Single channel: ch0=0xC0, vol0=15, only ch0 enabled, sample_req -> out_valid 5 edges later, audio_output=0x3C00 (960<<4).
REQ-034 Saturation: all channels 0xFF, vol 15, enabled -> 0x7FFF; all channels 0x00, vol 15 -> 0x8000.
REQ-035 Overrun: second sample_req 2 cycles after the first -> exactly one out_valid, result of the first snapshot, overrun=1 until reset.
REQ-036 Abort: reset pulsed 3 cycles after sample_req -> busy=0, no out_valid, audio_output=0; next request mixes correctly.
REQ-037 Mute: same stimulus as REQ-033 with master_mute=1 -> out_valid pulses, audio_output=0x0000.
